// File: rtl/alu_pkg.sv
// Shared ALU definitions: comparator FSM states, flag bundle and default operand width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_CLEAR = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
  localparam cmp_flags_t FLAGS_EQUAL = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};

  // A decided (mismatching) bit never reports equality.
  function automatic cmp_flags_t flags_from_bits(input logic gt, input logic lt);
    flags_from_bits = '{gt: gt, lt: lt, eq: 1'b0};
  endfunction

endpackage

// File: rtl/serial_comparator8_if.sv
// Start/busy/done handshake and operand/flag bundle of the serial magnitude comparator.
interface serial_comparator8_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_GT_B;
  logic             A_LT_B;
  logic             A_EQ_B;

  modport master (
    output start, A, B,
    input  busy, done, A_GT_B, A_LT_B, A_EQ_B
  );

  modport slave (
    input  start, A, B,
    output busy, done, A_GT_B, A_LT_B, A_EQ_B
  );

endinterface

// File: rtl/cmp_bit_cell.sv
// One-bit magnitude decision cell; reusable as the slice of a parallel comparator.
module cmp_bit_cell (
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic lt_o
);

  assign gt_o = a_i & ~b_i;
  assign lt_o = ~a_i & b_i;

endmodule

// File: rtl/serial_comparator8.sv
// Bit-serial MSB-first unsigned comparator: one compare cell iterated over the operand bits.
module serial_comparator8
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_comparator8_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmp_flags_t       flags_q, flags_d;
  logic             decided_q, decided_d;
  cmp_flags_t       dec_flags_q, dec_flags_d;

  logic bit_gt;
  logic bit_lt;
  logic bit_diff;

  cmp_bit_cell u_cell (
    .a_i  (sa_q[WIDTH-1]),
    .b_i  (sb_q[WIDTH-1]),
    .gt_o (bit_gt),
    .lt_o (bit_lt)
  );

  assign bit_diff = bit_gt | bit_lt;

  always_comb begin
    // NOTE: every _d gets a hold default first, so no path through the case can infer a latch.
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    decided_d   = decided_q;
    dec_flags_d = dec_flags_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SHIFT;
          sa_d        = bus.A;
          sb_d        = bus.B;
          cnt_d       = CNT_LAST;
          decided_d   = 1'b0;
          dec_flags_d = FLAGS_CLEAR;
        end
      end

      SHIFT: begin
        if (EARLY_EXIT && bit_diff) begin
          flags_d = flags_from_bits(bit_gt, bit_lt);
          state_d = DONE;
        end else if (cnt_q == '0) begin
          // Last bit: an earlier sticky decision outranks whatever the LSB says.
          state_d = DONE;
          if (decided_q) begin
            flags_d = dec_flags_q;
          end else if (bit_diff) begin
            flags_d = flags_from_bits(bit_gt, bit_lt);
          end else begin
            flags_d = FLAGS_EQUAL;
          end
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (bit_diff && !decided_q) begin
            decided_d   = 1'b1;
            dec_flags_d = flags_from_bits(bit_gt, bit_lt);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is cleared because an abandoned compare must leave no residue.
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      flags_q     <= FLAGS_CLEAR;
      decided_q   <= 1'b0;
      dec_flags_q <= FLAGS_CLEAR;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      decided_q   <= decided_d;
      dec_flags_q <= dec_flags_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.A_GT_B = flags_q.gt;
  assign bus.A_LT_B = flags_q.lt;
  assign bus.A_EQ_B = flags_q.eq;

  a_done_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> $onehot({flags_q.gt, flags_q.lt, flags_q.eq}));

  a_done_single_cycle: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |=> (state_q == IDLE));

endmodule

// File: tb/tb_serial_comparator8.sv
// Scoreboard bench: early-exit and full-length comparators driven in parallel, checked against a model.
module tb_serial_comparator8;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_comparator8_if #(.WIDTH(W)) bus [2] ();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected flags {GT,LT,EQ} and compare cycles, from plain arithmetic on the operands.
  function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee,
                                  output logic [2:0] flags, output int lat);
    int p;
    p = -1;
    flags = (a > b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
    for (int x = int'(a ^ b); x != 0; x = x >> 1) p++;
    lat = (ee && (a != b)) ? (W - p) : W;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    int         m_rem = 0;
    int         cyc_k = 0;
    exp_t       q[$];
    exp_t       e_m;
    exp_t       e_c;
    logic [2:0] exp_flags = 3'b000;

    serial_comparator8 #(.WIDTH(W), .EARLY_EXIT(k == 0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[k])
    );

    // Reference model: m_rem counts edges until the unit is back in IDLE.
    always @(posedge clk) begin
      cyc_k++;
      if (rst) begin
        m_rem = 0;
        q.delete();
      end else if (m_rem == 0) begin
        if (bus[k].start) begin
          ref_cmp(bus[k].A, bus[k].B, k == 0, e_m.flags, e_m.lat);
          e_m.acc_cyc = cyc_k;
          q.push_back(e_m);
          m_rem = e_m.lat + 1;
        end
      end else begin
        m_rem--;
      end
    end

    always begin
      @(posedge clk);
      #1;
      if (rst) exp_flags = 3'b000;
      check($sformatf("busy%0d", k), bus[k].busy, m_rem != 0);
      check($sformatf("done%0d", k), bus[k].done, m_rem == 1);
      if (bus[k].done) begin
        check($sformatf("done_pending%0d", k), q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e_c = q.pop_front();
          exp_flags = e_c.flags;
          check($sformatf("latency%0d", k), cyc_k - e_c.acc_cyc, e_c.lat);
        end
      end
      check($sformatf("flags%0d", k), {bus[k].A_GT_B, bus[k].A_LT_B, bus[k].A_EQ_B}, exp_flags);
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus[0].start = s;
    bus[0].A     = a;
    bus[0].B     = b;
    bus[1].start = s;
    bus[1].A     = a;
    bus[1].B     = b;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy0"}, bus[0].busy, 1'b0);
    check({name, "_done0"}, bus[0].done, 1'b0);
    check({name, "_flags0"}, {bus[0].A_GT_B, bus[0].A_LT_B, bus[0].A_EQ_B}, 3'b000);
    check({name, "_busy1"}, bus[1].busy, 1'b0);
    check({name, "_done1"}, bus[1].done, 1'b0);
    check({name, "_flags1"}, {bus[1].A_GT_B, bus[1].A_LT_B, bus[1].A_EQ_B}, 3'b000);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((g[0].m_rem != 0 || g[1].m_rem != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", t < 100, 1'b1);
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, a, b);
    @(negedge clk);
    drive(1'b0, a, b);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           r;

    drive(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");

    // Reset abandons an in-flight compare, then a zero/zero compare completes equal.
    drive(1'b1, W'(49), W'(52));
    @(negedge clk);
    drive(1'b0, W'(49), W'(52));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(W'(0), W'(0));

    issue(W'(97), W'(97));
    issue(W'(135), W'(26));
    issue(W'(254), W'(255));
    issue(W'(0), W'(1));

    // A start pulsed while busy is dropped.
    drive(1'b1, W'(252), W'(167));
    @(negedge clk);
    drive(1'b0, W'(252), W'(167));
    @(negedge clk);
    drive(1'b1, W'(26), W'(58));
    @(negedge clk);
    drive(1'b0, W'(26), W'(58));
    wait_idle();

    // Start held high: each unit re-accepts on its first IDLE cycle.
    drive(1'b1, W'(26), W'(58));
    @(negedge clk);
    drive(1'b1, W'(49), W'(52));
    repeat (11) @(negedge clk);
    drive(1'b0, W'(49), W'(52));
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      ra = W'($urandom);
      case (r % 4)
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      rst = (r < 2);
      drive($urandom_range(0, 9) < 6, ra, rb);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
